// File: rtl/datmem_axi_slave_if.sv
// ============================================================================
// Module   : datmem_axi_slave_if
// Brief    : AXI4-Lite bus bundle between the MEM-stage data master and the
//            data memory slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface datmem_axi_slave_if;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

`default_nettype wire

// File: rtl/datmem_axi_slave.sv
// ============================================================================
// Module   : datmem_axi_slave
// Brief    : AXI4-Lite slave word RAM with byte strobes and SLVERR on
//            out-of-range access. Optional macro DATMEM_WAIT_EN adds
//            WAIT_CYCLES of response delay per channel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module datmem_axi_slave #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  wire logic          ACLK,
    input  wire logic          ARSTN,
    datmem_axi_slave_if.slave  bus
);

    localparam int          c_idx_w  = $clog2(DEPTH_WORDS);
    localparam logic [32:0] c_span   = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [1:0]  c_okay   = 2'b00;
    localparam logic [1:0]  c_slverr = 2'b10;

    function automatic logic in_range(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && ({1'b0, off} < c_span);
    endfunction

    function automatic logic [c_idx_w-1:0] word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return off[c_idx_w+1:2];
    endfunction

    logic [31:0] r_mem [DEPTH_WORDS];

    logic        r_rdy_en;
    logic        r_aw_held;
    logic [31:0] r_awaddr;
    logic        r_w_held;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_b_busy;
    logic [1:0]  r_bresp;
    logic        r_r_busy;
    logic [1:0]  r_rresp;
    logic [31:0] r_rdata;

    logic        w_awready;
    logic        w_wready;
    logic        w_arready;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_ar_hs;
    logic        w_commit;
    logic [31:0] w_waddr;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic        w_wr_ok;
    logic        w_rd_ok;
    logic        w_bvalid;
    logic        w_rvalid;

`ifdef DATMEM_WAIT_EN
    localparam logic [3:0] c_wait = 4'(WAIT_CYCLES);
    logic [3:0] r_b_cnt;
    logic [3:0] r_r_cnt;

    assign w_bvalid = r_b_busy && (r_b_cnt == 4'd0);
    assign w_rvalid = r_r_busy && (r_r_cnt == 4'd0);

    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) begin
            r_b_cnt <= 4'd0;
            r_r_cnt <= 4'd0;
        end else begin
            if (w_commit)
                r_b_cnt <= c_wait;
            else if (r_b_cnt != 4'd0)
                r_b_cnt <= r_b_cnt - 4'd1;
            if (w_ar_hs)
                r_r_cnt <= c_wait;
            else if (r_r_cnt != 4'd0)
                r_r_cnt <= r_r_cnt - 4'd1;
        end
    end
`else
    assign w_bvalid = r_b_busy;
    assign w_rvalid = r_r_busy;
`endif

    // Readies stay low in reset and open on the first edge after release;
    // each channel stays closed for its whole response stage, wait included.
    assign w_awready = r_rdy_en & ~r_aw_held & ~r_b_busy;
    assign w_wready  = r_rdy_en & ~r_w_held  & ~r_b_busy;
    assign w_arready = r_rdy_en & ~r_r_busy;

    assign w_aw_hs = bus.AWVALID & w_awready;
    assign w_w_hs  = bus.WVALID  & w_wready;
    assign w_ar_hs = bus.ARVALID & w_arready;

    // A handshake in the current cycle counts as held so the commit can
    // happen on the same edge as the later of the two handshakes.
    assign w_commit = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
    assign w_waddr  = r_aw_held ? r_awaddr : bus.AWADDR;
    assign w_wdata  = r_w_held  ? r_wdata  : bus.WDATA;
    assign w_wstrb  = r_w_held  ? r_wstrb  : bus.WSTRB;
    assign w_wr_ok  = in_range(w_waddr);
    assign w_rd_ok  = in_range(bus.ARADDR);

    always_ff @(posedge ACLK) begin
        if (w_commit && w_wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (w_wstrb[i])
                    r_mem[word_idx(w_waddr)][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) begin
            r_rdy_en  <= 1'b0;
            r_aw_held <= 1'b0;
            r_awaddr  <= 32'd0;
            r_w_held  <= 1'b0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            r_b_busy  <= 1'b0;
            r_bresp   <= 2'b00;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_b_busy  <= 1'b1;
                r_bresp   <= w_wr_ok ? c_okay : c_slverr;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_awaddr  <= bus.AWADDR;
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= bus.WDATA;
                    r_wstrb  <= bus.WSTRB;
                end
                if (w_bvalid && bus.BREADY)
                    r_b_busy <= 1'b0;
            end
        end
    end

    // Memory is sampled at the AR edge, so a same-edge write is not seen.
    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) begin
            r_r_busy <= 1'b0;
            r_rresp  <= 2'b00;
            r_rdata  <= 32'd0;
        end else if (w_ar_hs) begin
            r_r_busy <= 1'b1;
            r_rresp  <= w_rd_ok ? c_okay : c_slverr;
            r_rdata  <= w_rd_ok ? r_mem[word_idx(bus.ARADDR)] : 32'd0;
        end else if (w_rvalid && bus.RREADY) begin
            r_r_busy <= 1'b0;
        end
    end

    assign bus.AWREADY = w_awready;
    assign bus.WREADY  = w_wready;
    assign bus.ARREADY = w_arready;
    assign bus.BVALID  = w_bvalid;
    assign bus.BRESP   = r_bresp;
    assign bus.RVALID  = w_rvalid;
    assign bus.RRESP   = r_rresp;
    assign bus.RDATA   = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_datmem_axi_slave.sv
// ============================================================================
// Module   : tb_datmem_axi_slave
// Brief    : Directed self-checking bench for datmem_axi_slave
//            (BASE_ADDR=0x100, DEPTH_WORDS=1024, WAIT_CYCLES=3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_datmem_axi_slave;

`ifdef DATMEM_WAIT_EN
    localparam int c_lat = 4;
`else
    localparam int c_lat = 1;
`endif

    logic ACLK;
    logic ARSTN;
    int   checks = 0;
    int   errors = 0;

    datmem_axi_slave_if bus ();

    datmem_axi_slave #(
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (32'h0000_0100),
        .WAIT_CYCLES (3)
    ) dut (
        .ACLK  (ACLK),
        .ARSTN (ARSTN),
        .bus   (bus)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Counts cycles from the handshake edge until the selected VALID rises.
    task automatic wait_valid(input bit is_b, output int n);
        n = 0;
        while (!(is_b ? bus.BVALID : bus.RVALID) && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] resp);
        int n;
        bus.AWADDR = addr; bus.AWVALID = 1'b1;
        bus.WDATA = data;  bus.WSTRB = strb; bus.WVALID = 1'b1;
        chk("wr_awready", {31'd0, bus.AWREADY}, 32'd1);
        tick();
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        wait_valid(1'b1, n);
        chk("wr_latency", n, c_lat - 1);
        chk("wr_bresp", {30'd0, bus.BRESP}, {30'd0, resp});
        tick();
        chk("wr_retired", {31'd0, bus.BVALID}, 32'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] resp);
        int n;
        bus.ARADDR = addr; bus.ARVALID = 1'b1;
        chk("rd_arready", {31'd0, bus.ARREADY}, 32'd1);
        tick();
        bus.ARVALID = 1'b0;
        wait_valid(1'b0, n);
        chk("rd_latency", n, c_lat - 1);
        chk("rd_rdata", bus.RDATA, data);
        chk("rd_rresp", {30'd0, bus.RRESP}, {30'd0, resp});
        tick();
        chk("rd_retired", {31'd0, bus.RVALID}, 32'd0);
    endtask

    initial begin
        int n;
        bit seen;

        // Reset held with master VALIDs asserted
        ARSTN = 1'b0;
        bus.AWADDR = 32'h110; bus.AWVALID = 1'b1;
        bus.WDATA = 32'h0; bus.WSTRB = 4'h0; bus.WVALID = 1'b0;
        bus.BREADY = 1'b1;
        bus.ARADDR = 32'h110; bus.ARVALID = 1'b1;
        bus.RREADY = 1'b1;
        repeat (3) tick();
        chk("rst_awready", {31'd0, bus.AWREADY}, 32'd0);
        chk("rst_wready",  {31'd0, bus.WREADY},  32'd0);
        chk("rst_arready", {31'd0, bus.ARREADY}, 32'd0);
        chk("rst_bvalid",  {31'd0, bus.BVALID},  32'd0);
        chk("rst_rvalid",  {31'd0, bus.RVALID},  32'd0);
        chk("rst_bresp",   {30'd0, bus.BRESP},   32'd0);
        chk("rst_rresp",   {30'd0, bus.RRESP},   32'd0);
        chk("rst_rdata",   bus.RDATA,            32'd0);
        bus.AWVALID = 1'b0; bus.ARVALID = 1'b0;
        ARSTN = 1'b1;
        tick();
        chk("rel_awready", {31'd0, bus.AWREADY}, 32'd1);
        chk("rel_wready",  {31'd0, bus.WREADY},  32'd1);
        chk("rel_arready", {31'd0, bus.ARREADY}, 32'd1);

        // Full word write then read with ignored low address bits
        do_write(32'h110, 32'hDEAD_BEEF, 4'hF, 2'b00);
        do_read (32'h113, 32'hDEAD_BEEF, 2'b00);

        // W three cycles ahead of AW, sparse strobe
        bus.WDATA = 32'h1122_3344; bus.WSTRB = 4'b0101; bus.WVALID = 1'b1;
        tick();
        bus.WVALID = 1'b0;
        chk("wfirst_wready",  {31'd0, bus.WREADY},  32'd0);
        chk("wfirst_awready", {31'd0, bus.AWREADY}, 32'd1);
        seen = 1'b0;
        repeat (2) begin seen |= bus.BVALID; tick(); end
        seen |= bus.BVALID;
        chk("wfirst_no_early_b", {31'd0, seen}, 32'd0);
        bus.AWADDR = 32'h110; bus.AWVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        wait_valid(1'b1, n);
        chk("wfirst_latency", n, c_lat - 1);
        chk("wfirst_bresp", {30'd0, bus.BRESP}, 32'd0);
        tick();
        do_read(32'h110, 32'hDE22_BE44, 2'b00);

        // AW ahead of W, zero strobe: OKAY, word unchanged
        bus.AWADDR = 32'h110; bus.AWVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        chk("afirst_awready", {31'd0, bus.AWREADY}, 32'd0);
        tick();
        bus.WDATA = 32'hFFFF_FFFF; bus.WSTRB = 4'b0000; bus.WVALID = 1'b1;
        tick();
        bus.WVALID = 1'b0;
        wait_valid(1'b1, n);
        chk("afirst_latency", n, c_lat - 1);
        chk("afirst_bresp", {30'd0, bus.BRESP}, 32'd0);
        tick();
        do_read(32'h110, 32'hDE22_BE44, 2'b00);

        // Range boundaries: last word, one past end (aliases word 0 if
        // truncated), below base
        do_write(32'h10FE, 32'hCAFE_F00D, 4'hF, 2'b00);
        do_read (32'h10FC, 32'hCAFE_F00D, 2'b00);
        do_write(32'h100,  32'h0123_4567, 4'hF, 2'b00);
        do_write(32'h1100, 32'hFFFF_FFFF, 4'hF, 2'b10);
        do_read (32'h100,  32'h0123_4567, 2'b00);
        do_read (32'h1100, 32'h0000_0000, 2'b10);
        do_read (32'h0FC,  32'h0000_0000, 2'b10);

        // Backpressure on both channels at once
        bus.BREADY = 1'b0; bus.RREADY = 1'b0;
        bus.AWADDR = 32'h120; bus.WDATA = 32'h5A5A_1234; bus.WSTRB = 4'hF;
        bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
        bus.ARADDR = 32'h110; bus.ARVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
        wait_valid(1'b1, n);
        chk("bp_latency", n, c_lat - 1);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen |= ~bus.BVALID | ~bus.RVALID | (bus.BRESP != 2'b00) |
                    (bus.RRESP != 2'b00) | (bus.RDATA != 32'hDE22_BE44) |
                    bus.AWREADY | bus.WREADY | bus.ARREADY;
            tick();
        end
        chk("bp_stable", {31'd0, seen}, 32'd0);
        bus.BREADY = 1'b1; bus.RREADY = 1'b1;
        tick();
        chk("bp_bvalid_drop", {31'd0, bus.BVALID}, 32'd0);
        chk("bp_rvalid_drop", {31'd0, bus.RVALID}, 32'd0);
        chk("bp_awready",     {31'd0, bus.AWREADY}, 32'd1);
        chk("bp_arready",     {31'd0, bus.ARREADY}, 32'd1);
        do_read(32'h120, 32'h5A5A_1234, 2'b00);

        // Read and write of the same word on the same edge
        bus.AWADDR = 32'h120; bus.WDATA = 32'h0BAD_CAFE; bus.WSTRB = 4'hF;
        bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
        bus.ARADDR = 32'h120; bus.ARVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
        wait_valid(1'b0, n);
        chk("rw_latency", n, c_lat - 1);
        chk("rw_old_data", bus.RDATA, 32'h5A5A_1234);
        tick();
        do_read(32'h120, 32'h0BAD_CAFE, 2'b00);

        // Asynchronous reset mid-response: nothing emitted afterwards
        bus.AWADDR = 32'h124; bus.WDATA = 32'h7777_7777; bus.WSTRB = 4'hF;
        bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        ARSTN = 1'b0;
        #1;
        chk("arst_bvalid",  {31'd0, bus.BVALID},  32'd0);
        chk("arst_awready", {31'd0, bus.AWREADY}, 32'd0);
        repeat (2) tick();
        ARSTN = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen |= bus.BVALID | bus.RVALID;
        end
        chk("arst_no_resp", {31'd0, seen}, 32'd0);
        do_read(32'h110, 32'hDE22_BE44, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
